acc_write_ctrl: RTL and testbench

Per-column write sequencer that drives the write ports of one column's 8-entry partial-sum accumulator. For each tile it first issues 8 compensation (preload) writes, rows 0..7. It then waits a column-dependent skew so that systolic-array partial sums for that column have emerged. Finally it issues 8 accumulate writes, rows 0..7. It sits between the array/compensation control and the accumulator, one instance per column.

---
 rtl/acc_write_ctrl_if.sv | 26 ++
 rtl/acc_write_ctrl.sv | 144 ++++++++++++++
 tb/tb_acc_write_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/acc_write_ctrl_if.sv
// Control bus between the array/compensation sequencer and one column's
// accumulator write ports.
interface acc_write_ctrl_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              start;
  logic [2:0]        Col;
  logic              CACC_Wr_en;
  logic [ADDR_W-1:0] CAcc_Wr_Addr;
  logic              ACC_Wr_en;
  logic [ADDR_W-1:0] Acc_Wr_Addr;
  logic              busy;
  logic              done;

  // Issues tile starts and observes the write ports.
  modport master (
    output start, Col,
    input  CACC_Wr_en, CAcc_Wr_Addr, ACC_Wr_en, Acc_Wr_Addr, busy, done
  );

  // The write sequencer itself.
  modport slave (
    input  start, Col,
    output CACC_Wr_en, CAcc_Wr_Addr, ACC_Wr_en, Acc_Wr_Addr, busy, done
  );
endinterface

// File: rtl/acc_write_ctrl.sv
// Per-column accumulator write sequencer: ROWS compensation writes, a
// column-dependent skew gap, ROWS accumulate writes, then a done pulse.
module acc_write_ctrl #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned SKEW_BASE = 1,
  parameter int unsigned SKEW_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  acc_write_ctrl_if.slave   bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StComp = 3'd1;
  localparam logic [2:0] StSkew = 3'd2;
  localparam logic [2:0] StAcc  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(ROWS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic [2:0]        col_q, col_d;
  logic              cen_q, cen_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic              aen_q, aen_d;
  logic [ADDR_W-1:0] aaddr_q, aaddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SKEW_W-1:0] skew_total;
  assign skew_total = SKEW_W'(SKEW_BASE) + SKEW_W'(col_q);

  // Next-state and next-output decode; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    skew_d  = skew_q;
    col_d   = col_q;
    cen_d   = 1'b0;
    caddr_d = caddr_q;
    aen_d   = 1'b0;
    aaddr_d = aaddr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StComp;
          col_d   = bus.Col;
          row_d   = '0;
          cen_d   = 1'b1;
          caddr_d = '0;
          aaddr_d = '0;
          busy_d  = 1'b1;
        end
      end
      StComp: begin
        if (row_q == LastRow) begin
          row_d = '0;
          // Zero skew goes straight to accumulate with no idle cycle.
          if (skew_total == '0) begin
            state_d = StAcc;
            aen_d   = 1'b1;
            aaddr_d = '0;
          end else begin
            state_d = StSkew;
            skew_d  = skew_total - SKEW_W'(1);
          end
        end else begin
          row_d   = row_q + ADDR_W'(1);
          cen_d   = 1'b1;
          caddr_d = row_q + ADDR_W'(1);
        end
      end
      StSkew: begin
        if (skew_q == '0) begin
          state_d = StAcc;
          aen_d   = 1'b1;
          aaddr_d = '0;
        end else begin
          skew_d = skew_q - SKEW_W'(1);
        end
      end
      StAcc: begin
        if (row_q == LastRow) begin
          row_d   = '0;
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          row_d   = row_q + ADDR_W'(1);
          aen_d   = 1'b1;
          aaddr_d = row_q + ADDR_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      skew_q  <= '0;
      col_q   <= '0;
      cen_q   <= 1'b0;
      caddr_q <= '0;
      aen_q   <= 1'b0;
      aaddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      skew_q  <= skew_d;
      col_q   <= col_d;
      cen_q   <= cen_d;
      caddr_q <= caddr_d;
      aen_q   <= aen_d;
      aaddr_q <= aaddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.CACC_Wr_en   = cen_q;
  assign bus.CAcc_Wr_Addr = caddr_q;
  assign bus.ACC_Wr_en    = aen_q;
  assign bus.Acc_Wr_Addr  = aaddr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_acc_write_ctrl.sv
// Bench for acc_write_ctrl: two instances (SKEW_BASE=1 and SKEW_BASE=0) share
// the same stimulus; a timeline model predicts every output on every cycle.
module tb_acc_write_ctrl;

  localparam int ROWS = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] col   = 3'd0;

  always #5 clk = ~clk;

  acc_write_ctrl_if #(.ADDR_W(3)) bus_a ();
  acc_write_ctrl_if #(.ADDR_W(3)) bus_b ();

  assign bus_a.start = start;
  assign bus_a.Col   = col;
  assign bus_b.start = start;
  assign bus_b.Col   = col;

  acc_write_ctrl #(.ROWS(8), .ADDR_W(3), .SKEW_BASE(1), .SKEW_W(5)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  acc_write_ctrl #(.ROWS(8), .ADDR_W(3), .SKEW_BASE(0), .SKEW_W(5)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // {CACC_Wr_en, CAcc_Wr_Addr, ACC_Wr_en, Acc_Wr_Addr, busy, done}
  logic [9:0] obs [2];
  assign obs[0] = {bus_a.CACC_Wr_en, bus_a.CAcc_Wr_Addr, bus_a.ACC_Wr_en,
                   bus_a.Acc_Wr_Addr, bus_a.busy, bus_a.done};
  assign obs[1] = {bus_b.CACC_Wr_en, bus_b.CAcc_Wr_Addr, bus_b.ACC_Wr_en,
                   bus_b.Acc_Wr_Addr, bus_b.busy, bus_b.done};

  int errors = 0;
  int checks = 0;

  // Model: a tile is a timeline indexed by k = edges since the accepted start.
  bit m_act [2];
  int m_k   [2];
  int m_col [2];
  int m_ca  [2];
  int m_aa  [2];

  function automatic int skew_of(int i);
    return ((i == 0) ? 1 : 0) + m_col[i];
  endfunction

  function automatic logic [9:0] expect_of(int i);
    int  s;
    bit  cen, aen, dn;
    s   = skew_of(i);
    cen = m_act[i] && (m_k[i] < ROWS);
    aen = m_act[i] && (m_k[i] >= ROWS + s) && (m_k[i] < 2 * ROWS + s);
    dn  = m_act[i] && (m_k[i] == 2 * ROWS + s);
    return {cen, 3'(m_ca[i]), aen, 3'(m_aa[i]), m_act[i], dn};
  endfunction

  task automatic model_edge(int i, bit rst_in, bit start_in, int col_in);
    int s;
    if (!rst_in) begin
      m_act[i] = 0; m_k[i] = 0; m_col[i] = 0; m_ca[i] = 0; m_aa[i] = 0;
    end else if (!m_act[i]) begin
      if (start_in) begin
        m_act[i] = 1; m_k[i] = 0; m_col[i] = col_in; m_ca[i] = 0; m_aa[i] = 0;
      end
    end else begin
      m_k[i]++;
      if (m_k[i] > 2 * ROWS + skew_of(i)) m_act[i] = 0;
    end
    if (m_act[i]) begin
      s = skew_of(i);
      if (m_k[i] < ROWS) m_ca[i] = m_k[i];
      else if (m_k[i] >= ROWS + s && m_k[i] < 2 * ROWS + s) m_aa[i] = m_k[i] - ROWS - s;
    end
  endtask

  // Single compare process: advance the model on each rising edge, check on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_edge(i, rst_n, start, int'(col));
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [9:0] e;
        e = expect_of(i);
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL cycle_match inst=%0d t=%0t got=%b required=%b", i, $time, obs[i], e);
        end
        checks++;
        if (obs[i][9] === 1'b1 && obs[i][5] === 1'b1) begin
          errors++;
          $display("FAIL exclusive inst=%0d t=%0t got both enables high, required at most one", i,
                   $time);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_lit(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Pulse start for one edge; returns at the falling edge after that edge (E0).
  task automatic start_tile(logic [2:0] c);
    col   = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check_lit("reset_busy_a", int'(bus_a.busy), 0);
    check_lit("reset_cen_a", int'(bus_a.CACC_Wr_en), 0);
    rst_n = 1'b1;
    step();

    // Tile with Col=0: skew 1 on instance A, skew 0 on instance B.
    start_tile(3'd0);
    check_lit("t1_e0_cen", int'(bus_a.CACC_Wr_en), 1);
    check_lit("t1_e0_caddr", int'(bus_a.CAcc_Wr_Addr), 0);
    check_lit("t1_e0_busy", int'(bus_a.busy), 1);
    for (int e = 1; e <= 18; e++) begin
      step();
      if (e == 7) check_lit("t1_e7_caddr", int'(bus_a.CAcc_Wr_Addr), 7);
      if (e == 8) check_lit("t1_e8_gap_a", int'(bus_a.ACC_Wr_en), 0);
      if (e == 8) check_lit("t3_e8_acc_b", int'(bus_b.ACC_Wr_en), 1);
      if (e == 9) check_lit("t1_e9_acc_a", int'(bus_a.ACC_Wr_en), 1);
      if (e == 9) check_lit("t1_e9_aaddr", int'(bus_a.Acc_Wr_Addr), 0);
      if (e == 16) check_lit("t3_e16_done_b", int'(bus_b.done), 1);
      if (e == 17) check_lit("t1_e17_done_a", int'(bus_a.done), 1);
      if (e == 18) check_lit("t1_e18_busy_a", int'(bus_a.busy), 0);
    end
    repeat (2) step();

    // Col=7: instance A skews 8 cycles.
    start_tile(3'd7);
    for (int e = 1; e <= 26; e++) begin
      step();
      if (e == 15) check_lit("t2_e15_gap", int'(bus_a.ACC_Wr_en), 0);
      if (e == 16) check_lit("t2_e16_acc", int'(bus_a.ACC_Wr_en), 1);
      if (e == 24) check_lit("t2_e24_done", int'(bus_a.done), 1);
    end

    // Start re-pulsed in COMP, SKEW and DONE; then right after busy falls.
    start_tile(3'd3);
    for (int e = 1; e <= 24; e++) begin
      start = (e == 3 || e == 9 || e == 21 || e == 22);
      step();
      if (e == 20) check_lit("t4_e20_done", int'(bus_a.done), 1);
      if (e == 21) check_lit("t4_e21_busy", int'(bus_a.busy), 0);
      if (e == 22) check_lit("t4_e22_restart", int'(bus_a.CACC_Wr_en), 1);
      if (e == 22) check_lit("t4_e22_caddr", int'(bus_a.CAcc_Wr_Addr), 0);
    end
    start = 1'b0;
    repeat (30) step();

    // Reset pulse while instance A writes accumulate row 3.
    start_tile(3'd0);
    repeat (12) step();
    check_lit("t5_pre_aaddr", int'(bus_a.Acc_Wr_Addr), 3);
    rst_n = 1'b0;
    step();
    check_lit("t5_reset_obs", int'(obs[0]), 0);
    rst_n = 1'b1;
    repeat (10) step();
    start_tile(3'd1);
    repeat (22) step();

    // Col changes mid-tile do not affect the running tile.
    start_tile(3'd2);
    col = 3'd5;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 10) check_lit("t6_e10_gap", int'(bus_a.ACC_Wr_en), 0);
      if (e == 11) check_lit("t6_e11_acc", int'(bus_a.ACC_Wr_en), 1);
    end
    start_tile(3'd5);
    for (int e = 1; e <= 24; e++) begin
      step();
      if (e == 13) check_lit("t6b_e13_gap", int'(bus_a.ACC_Wr_en), 0);
      if (e == 14) check_lit("t6b_e14_acc", int'(bus_a.ACC_Wr_en), 1);
    end

    // Random traffic: starts, column changes and occasional resets.
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(0, 3) == 0);
      col   = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 59) != 0);
      step();
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
